// File: rtl/word_ser_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : word_ser_pkg                                           |
// | Purpose : Shared state encoding and bit-order constants for the  |
// |           word serializer.                                       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package word_ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/word_serializer_bit_period_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : bit_period_timer                                       |
// | Purpose : Counts DIV clocks per serial bit; one-cycle tick on    |
// |           the last cycle of each bit period.                     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module bit_period_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int              c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n || restart || !run) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CW'(1);
        end
    end

    assign tick = run && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : word_serializer                                        |
// | Purpose : Parallel word to framed serial stream with a one-word  |
// |           holding buffer. Define WORD_SER_PARITY_EN to append an |
// |           even-parity bit to every frame.                        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module word_serializer
    import word_ser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_lsb_first,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int               c_BCW      = $clog2(WIDTH + 1);
    localparam logic [c_BCW-1:0] c_LAST_BIT = c_BCW'(WIDTH - 1);
`ifdef WORD_SER_PARITY_EN
    localparam logic c_END_IN_SHIFT = 1'b0;
`else
    localparam logic c_END_IN_SHIFT = 1'b1;
`endif

    ser_state_t       r_state, w_state_next;
    logic [WIDTH-1:0] r_hold_data, r_shift;
    logic             r_hold_lsb, r_hold_full, r_lsb_first;
    logic [c_BCW-1:0] r_bit_cnt;
    logic             r_ser_out, r_ser_valid, r_frame_start, r_frame_end;
`ifdef WORD_SER_PARITY_EN
    logic             r_parity;
`endif
    logic             w_tick, w_load, w_advance, w_accept, w_cur_bit;

    assign w_accept  = in_valid && in_ready;
    assign w_cur_bit = (r_lsb_first == LSB_FIRST) ? r_shift[0] : r_shift[WIDTH-1];

    bit_period_timer #(.DIV(DIV)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (r_state != IDLE),
        .restart (w_load),
        .tick    (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
`ifdef WORD_SER_PARITY_EN
                        w_state_next = PARITY;
`else
                        // Frame boundary: chain straight into a buffered word
                        w_load       = r_hold_full;
                        w_state_next = r_hold_full ? SHIFT : IDLE;
`endif
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
`ifdef WORD_SER_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_load       = r_hold_full;
                    w_state_next = r_hold_full ? SHIFT : IDLE;
                end
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_hold_data   <= '0;
            r_hold_lsb    <= 1'b0;
            r_hold_full   <= 1'b0;
            r_shift       <= '0;
            r_lsb_first   <= 1'b0;
            r_bit_cnt     <= '0;
            r_ser_out     <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
`ifdef WORD_SER_PARITY_EN
            r_parity      <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_hold_data <= in_data;
                r_hold_lsb  <= in_lsb_first;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_shift     <= r_hold_data;
                r_lsb_first <= r_hold_lsb;
                r_bit_cnt   <= '0;
`ifdef WORD_SER_PARITY_EN
                r_parity    <= ^r_hold_data;
`endif
            end else if (w_advance) begin
                r_shift   <= (r_lsb_first == LSB_FIRST) ? {1'b0, r_shift[WIDTH-1:1]}
                                                        : {r_shift[WIDTH-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + c_BCW'(1);
            end

            // Output stage trails the shifter by one cycle
            if (r_state == SHIFT) begin
                r_ser_out     <= w_cur_bit;
                r_ser_valid   <= 1'b1;
                r_frame_start <= (r_bit_cnt == '0);
                r_frame_end   <= c_END_IN_SHIFT && (r_bit_cnt == c_LAST_BIT);
            end
`ifdef WORD_SER_PARITY_EN
            else if (r_state == PARITY) begin
                r_ser_out     <= r_parity;
                r_ser_valid   <= 1'b1;
                r_frame_start <= 1'b0;
                r_frame_end   <= 1'b1;
            end
`endif
            else begin
                r_ser_out     <= 1'b0;
                r_ser_valid   <= 1'b0;
                r_frame_start <= 1'b0;
                r_frame_end   <= 1'b0;
            end
        end
    end

    assign in_ready    = !r_hold_full && reset_n;
    assign ser_out     = r_ser_out;
    assign ser_valid   = r_ser_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign busy        = (r_state != IDLE) || r_hold_full || r_ser_valid;

endmodule
`default_nettype wire
